// File: rtl/lcd_display_driver.sv
// HD44780 16x2 driver (8-bit, write-only): prints a latched 32-bit word as 8 hex digits on line 1.
// Define LCD_SECOND_LINE_EN to also print value2 on line 2.
module lcd_display_driver #(
    parameter int EN_WIDTH    = 5,
    parameter int EXEC_WIDTH  = 12,
    parameter int CLEAR_WIDTH = 17,
    parameter int POWER_WIDTH = 20,
    parameter int LCD_WIDTH   = 11
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [31:0] value,
    input  logic [31:0] value2,
    output logic [7:0]  lcd_data,
    output logic        lcd_rs,
    output logic        lcd_rw,
    output logic        lcd_en,
    output logic        lcd_on,
    output logic        lcd_blon,
    output logic        lcd_done,
    output logic        busy
);

    localparam int W_A = (EN_WIDTH > EXEC_WIDTH) ? EN_WIDTH : EXEC_WIDTH;
    localparam int W_B = (CLEAR_WIDTH > POWER_WIDTH) ? CLEAR_WIDTH : POWER_WIDTH;
    localparam int W_C = (W_A > W_B) ? W_A : W_B;
    localparam int CW  = (W_C > LCD_WIDTH) ? W_C : LCD_WIDTH;

    localparam logic [CW-1:0] EN_LOAD    = CW'((1 << EN_WIDTH) - 1);
    localparam logic [CW-1:0] EXEC_LOAD  = CW'((1 << EXEC_WIDTH) - 1);
    localparam logic [CW-1:0] CLEAR_LOAD = CW'((1 << CLEAR_WIDTH) - 1);
    // One cycle of the power wait is spent arming the counter, hence -2.
    localparam logic [CW-1:0] POWER_LOAD = CW'((1 << POWER_WIDTH) - 2);
    localparam logic [CW-1:0] DONE_LOAD  = CW'((1 << LCD_WIDTH) - 1);
    localparam logic [CW-1:0] ONE        = CW'(1);

    typedef enum logic [3:0] {
        S_POWER_WAIT,
        S_INIT,
        S_IDLE,
        S_CLEAR,
        S_ADDR1,
        S_DIGITS1,
`ifdef LCD_SECOND_LINE_EN
        S_ADDR2,
        S_DIGITS2,
`endif
        S_DONE
    } state_t;

    typedef enum logic [1:0] {P_SETUP, P_EN_HI, P_EN_LO, P_EXEC} phase_t;

    state_t        state, nxt_state;
    phase_t        phase;
    logic [CW-1:0] cnt;
    logic [2:0]    idx, nxt_idx;
    logic [31:0]   value_q;
    logic          start_q, pending, pw_armed;
    logic          rise, accept, advance;
    logic [7:0]    nxt_byte;
    logic          nxt_rs;
    logic [3:0]    nib;

`ifdef LCD_SECOND_LINE_EN
    logic [31:0]   value2_q;
`else
    logic          unused_value2;
    assign unused_value2 = ^value2;
`endif

    function automatic logic [7:0] hex_char(input logic [3:0] n);
        return (n < 4'd10) ? (8'h30 + {4'h0, n}) : (8'h37 + {4'h0, n});
    endfunction

    assign lcd_rw = 1'b0;
    assign rise   = start & ~start_q;

    always_comb begin
        nxt_state = S_IDLE;
        nxt_idx   = 3'd0;
        case (state)
            S_POWER_WAIT: nxt_state = S_INIT;
            S_INIT: begin
                if (idx != 3'd3) begin
                    nxt_state = S_INIT;
                    nxt_idx   = idx + 3'd1;
                end
            end
            S_IDLE:  nxt_state = S_CLEAR;
            S_CLEAR: nxt_state = S_ADDR1;
            S_ADDR1: nxt_state = S_DIGITS1;
            S_DIGITS1: begin
                if (idx != 3'd7) begin
                    nxt_state = S_DIGITS1;
                    nxt_idx   = idx + 3'd1;
                end else begin
`ifdef LCD_SECOND_LINE_EN
                    nxt_state = S_ADDR2;
`else
                    nxt_state = S_DONE;
`endif
                end
            end
`ifdef LCD_SECOND_LINE_EN
            S_ADDR2: nxt_state = S_DIGITS2;
            S_DIGITS2: begin
                if (idx != 3'd7) begin
                    nxt_state = S_DIGITS2;
                    nxt_idx   = idx + 3'd1;
                end else begin
                    nxt_state = S_DONE;
                end
            end
`endif
            default: nxt_state = S_IDLE;
        endcase
    end

    // Byte for the step being entered; digits are sent most significant nibble first.
    always_comb begin
        nxt_byte = 8'h00;
        nxt_rs   = 1'b0;
        nib      = value_q[{~nxt_idx, 2'b00} +: 4];
        case (nxt_state)
            S_INIT: begin
                case (nxt_idx)
                    3'd0:    nxt_byte = 8'h38;
                    3'd1:    nxt_byte = 8'h0C;
                    3'd2:    nxt_byte = 8'h06;
                    default: nxt_byte = 8'h01;
                endcase
            end
            S_CLEAR: nxt_byte = 8'h01;
            S_ADDR1: nxt_byte = 8'h80;
            S_DIGITS1: begin
                nxt_rs   = 1'b1;
                nxt_byte = hex_char(nib);
            end
`ifdef LCD_SECOND_LINE_EN
            S_ADDR2: nxt_byte = 8'hC0;
            S_DIGITS2: begin
                nib      = value2_q[{~nxt_idx, 2'b00} +: 4];
                nxt_rs   = 1'b1;
                nxt_byte = hex_char(nib);
            end
`endif
            default: nxt_byte = 8'h00;
        endcase
    end

    always_comb begin
        accept  = (state == S_IDLE) && (rise || pending);
        advance = 1'b0;
        case (state)
            S_POWER_WAIT: advance = pw_armed && (cnt == '0);
            S_IDLE:       advance = accept;
            S_DONE:       advance = 1'b0;
            default:      advance = (phase == P_EXEC) && (cnt == '0);
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= S_POWER_WAIT;
            phase    <= P_SETUP;
            cnt      <= '0;
            idx      <= 3'd0;
            value_q  <= 32'h0;
`ifdef LCD_SECOND_LINE_EN
            value2_q <= 32'h0;
`endif
            start_q  <= 1'b0;
            pending  <= 1'b0;
            pw_armed <= 1'b0;
            lcd_data <= 8'h00;
            lcd_rs   <= 1'b0;
            lcd_en   <= 1'b0;
            lcd_on   <= 1'b0;
            lcd_blon <= 1'b0;
            lcd_done <= 1'b0;
            busy     <= 1'b1;
        end else begin
            lcd_on   <= 1'b1;
            lcd_blon <= 1'b1;
            start_q  <= start;
            if (rise && state != S_IDLE)
                pending <= 1'b1;

            if (advance) begin
                state <= nxt_state;
                idx   <= nxt_idx;
                busy  <= (nxt_state != S_IDLE);
                if (state == S_IDLE) begin
                    value_q  <= value;
`ifdef LCD_SECOND_LINE_EN
                    value2_q <= value2;
`endif
                    pending  <= 1'b0;
                end
                if (nxt_state == S_DONE) begin
                    lcd_done <= 1'b1;
                    cnt      <= DONE_LOAD;
                end else if (nxt_state != S_IDLE) begin
                    phase    <= P_SETUP;
                    lcd_data <= nxt_byte;
                    lcd_rs   <= nxt_rs;
                    cnt      <= '0;
                end
            end else begin
                case (state)
                    S_POWER_WAIT: begin
                        if (!pw_armed) begin
                            pw_armed <= 1'b1;
                            cnt      <= POWER_LOAD;
                        end else begin
                            cnt <= cnt - ONE;
                        end
                    end
                    S_IDLE: ;
                    S_DONE: begin
                        if (cnt == '0) begin
                            lcd_done <= 1'b0;
                            busy     <= 1'b0;
                            state    <= S_IDLE;
                        end else begin
                            cnt <= cnt - ONE;
                        end
                    end
                    default: begin
                        case (phase)
                            P_SETUP: begin
                                phase  <= P_EN_HI;
                                lcd_en <= 1'b1;
                                cnt    <= EN_LOAD;
                            end
                            P_EN_HI: begin
                                if (cnt == '0) begin
                                    phase  <= P_EN_LO;
                                    lcd_en <= 1'b0;
                                    cnt    <= EN_LOAD;
                                end else begin
                                    cnt <= cnt - ONE;
                                end
                            end
                            P_EN_LO: begin
                                if (cnt == '0) begin
                                    phase <= P_EXEC;
                                    cnt   <= (lcd_data == 8'h01 && !lcd_rs) ? CLEAR_LOAD : EXEC_LOAD;
                                end else begin
                                    cnt <= cnt - ONE;
                                end
                            end
                            P_EXEC: cnt <= cnt - ONE;
                        endcase
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_lcd_display_driver.sv
// Directed bench for lcd_display_driver with shortened timing parameters (power 256, clear 64, exec 16, enable 4 cycles).
module tb_lcd_display_driver;

    localparam int POWER_CYC = 256;
    localparam int DONE_CYC  = 2048;
    localparam int EN_CYC    = 4;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic [31:0] value = 32'h0;
    logic [31:0] value2 = 32'h0;
    logic [7:0]  lcd_data;
    logic        lcd_rs, lcd_rw, lcd_en, lcd_on, lcd_blon, lcd_done, busy;

    int vectors = 0;
    int miscompares = 0;

    logic [8:0] seen_q[$];
    logic [8:0] exp_q[$];
    int         en_count = 0, done_count = 0, done_len = 0, en_bad = 0;
    int         en_hi = 0, done_hi = 0;
    logic       prev_en = 1'b0, prev_done = 1'b0;
    logic [8:0] en_word = 9'h0;

    always #5 clk = ~clk;

    lcd_display_driver #(
        .EN_WIDTH(2), .EXEC_WIDTH(4), .CLEAR_WIDTH(6), .POWER_WIDTH(8), .LCD_WIDTH(11)
    ) dut (
        .clk(clk), .reset(reset), .start(start), .value(value), .value2(value2),
        .lcd_data(lcd_data), .lcd_rs(lcd_rs), .lcd_rw(lcd_rw), .lcd_en(lcd_en),
        .lcd_on(lcd_on), .lcd_blon(lcd_blon), .lcd_done(lcd_done), .busy(busy)
    );

    // Strobe and done-pulse recorder, sampled just after each rising edge.
    always @(posedge clk) begin
        #1;
        if (reset) begin
            prev_en = 1'b0; prev_done = 1'b0; en_hi = 0; done_hi = 0;
        end else begin
            if (lcd_en && !prev_en) begin
                seen_q.push_back({lcd_rs, lcd_data});
                en_count++;
                en_word = {lcd_rs, lcd_data};
                en_hi = 0;
            end
            if (lcd_en) begin
                en_hi++;
                if ({lcd_rs, lcd_data} !== en_word) en_bad++;
            end
            if (!lcd_en && prev_en && en_hi != EN_CYC) en_bad++;
            if (lcd_done && !prev_done) begin
                done_count++;
                done_hi = 0;
            end
            if (lcd_done) done_hi++;
            if (!lcd_done && prev_done) done_len = done_hi;
            prev_en = lcd_en;
            prev_done = lcd_done;
        end
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        assert (got === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic check_seq(input string tag);
        chk({tag, " count"}, 32'(seen_q.size()), 32'(exp_q.size()));
        for (int i = 0; i < exp_q.size(); i++)
            chk($sformatf("%s[%0d]", tag, i),
                (i < seen_q.size()) ? 32'(seen_q[i]) : 32'bx, 32'(exp_q[i]));
    endtask

    task automatic wait_busy_low(input string tag, input int limit);
        int n = 0;
        while (busy !== 1'b0 && n < limit) begin
            @(negedge clk);
            n++;
        end
        chk({tag, " busy low"}, 32'(busy), 32'h0);
    endtask

    task automatic wait_done(input string tag, input int base, input int limit);
        int n = 0;
        while (!(done_count > base && lcd_done === 1'b0) && n < limit) begin
            @(negedge clk);
            n++;
        end
        chk({tag, " done pulse seen"}, 32'(done_count > base), 32'h1);
    endtask

    task automatic add_line2_zero();
`ifdef LCD_SECOND_LINE_EN
        exp_q.push_back(9'h0C0);
        for (int i = 0; i < 8; i++) exp_q.push_back(9'h130);
`endif
    endtask

    // Releases reset and checks the full power-up wait and init command sequence.
    task automatic power_up(input string tag);
        int base;
        @(negedge clk);
        reset = 1'b0;
        seen_q.delete();
        base = en_count;
        @(negedge clk);
        chk({tag, " lcd_on"}, 32'(lcd_on), 32'h1);
        chk({tag, " lcd_blon"}, 32'(lcd_blon), 32'h1);
        repeat (POWER_CYC - 1) @(negedge clk);
        chk({tag, " no strobe in wait"}, 32'(en_count - base), 32'h0);
        chk({tag, " en low at wait end"}, 32'(lcd_en), 32'h0);
        chk({tag, " setup data"}, 32'({lcd_rs, lcd_data}), 32'h038);
        @(negedge clk);
        chk({tag, " first strobe"}, 32'(lcd_en), 32'h1);
        wait_busy_low(tag, 1000);
        exp_q = {9'h038, 9'h00C, 9'h006, 9'h001};
        check_seq({tag, " init"});
    endtask

    initial begin
        int dbase, ebase, n;

        // Reset values
        reset = 1'b1;
        repeat (3) @(negedge clk);
        chk("rst lcd_data", 32'(lcd_data), 32'h00);
        chk("rst lcd_rs", 32'(lcd_rs), 32'h0);
        chk("rst lcd_rw", 32'(lcd_rw), 32'h0);
        chk("rst lcd_en", 32'(lcd_en), 32'h0);
        chk("rst lcd_done", 32'(lcd_done), 32'h0);
        chk("rst busy", 32'(busy), 32'h1);
        chk("rst lcd_on", 32'(lcd_on), 32'h0);
        chk("rst lcd_blon", 32'(lcd_blon), 32'h0);

        power_up("pwr");

        // Display 0x1234ABCD
        value = 32'h1234ABCD;
        value2 = 32'h0;
        seen_q.delete();
        dbase = done_count;
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        chk("disp busy after accept", 32'(busy), 32'h1);
        wait_done("disp", dbase, 20000);
        chk("disp done length", 32'(done_len), 32'(DONE_CYC));
        chk("disp busy after done", 32'(busy), 32'h0);
        exp_q = {9'h001, 9'h080, 9'h131, 9'h132, 9'h133, 9'h134,
                 9'h141, 9'h142, 9'h143, 9'h144};
        add_line2_zero();
        check_seq("disp");

        // Level held high: no retrigger
        ebase = en_count;
        repeat (10000) @(negedge clk);
        chk("hold strobes", 32'(en_count - ebase), 32'h0);
        chk("hold done pulses", 32'(done_count - dbase), 32'h1);
        chk("hold lcd_done", 32'(lcd_done), 32'h0);
        chk("hold busy", 32'(busy), 32'h0);
        start = 1'b0;

        // Request during INIT is served afterwards with the value present at acceptance
        reset = 1'b1;
        repeat (2) @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        seen_q.delete();
        ebase = en_count;
        dbase = done_count;
        n = 0;
        while (en_count == ebase && n < 1000) begin
            @(negedge clk);
            n++;
        end
        chk("pend init started", 32'(en_count > ebase), 32'h1);
        chk("pend still busy", 32'(busy), 32'h1);
        value = 32'hAAAA5555;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        value = 32'h0F9E5A70;
        wait_done("pend", dbase, 20000);
        exp_q = {9'h038, 9'h00C, 9'h006, 9'h001, 9'h001, 9'h080,
                 9'h130, 9'h146, 9'h139, 9'h145, 9'h135, 9'h141, 9'h137, 9'h130};
        add_line2_zero();
        check_seq("pend");
        repeat (300) @(negedge clk);
        chk("pend single done", 32'(done_count - dbase), 32'h1);
        chk("pend idle", 32'(busy), 32'h0);

        // Reset during the 4th digit strobe
        value = 32'h1234ABCD;
        seen_q.delete();
        @(negedge clk);
        start = 1'b1;
        n = 0;
        while (seen_q.size() < 6 && n < 2000) begin
            @(negedge clk);
            n++;
        end
        chk("midrst reached digit 4", 32'(seen_q.size() >= 6), 32'h1);
        chk("midrst en high", 32'(lcd_en), 32'h1);
        chk("midrst digit 4 byte", (seen_q.size() >= 6) ? 32'(seen_q[5]) : 32'bx, 32'h134);
        #2 reset = 1'b1;
        #1;
        chk("midrst en", 32'(lcd_en), 32'h0);
        chk("midrst done", 32'(lcd_done), 32'h0);
        chk("midrst busy", 32'(busy), 32'h1);
        chk("midrst data", 32'(lcd_data), 32'h00);
        chk("midrst lcd_on", 32'(lcd_on), 32'h0);
        start = 1'b0;
        repeat (3) @(negedge clk);
        power_up("midrst pwr");

`ifdef LCD_SECOND_LINE_EN
        // Second line: zeros on line 1, all-F on line 2
        value = 32'h0;
        value2 = 32'hFFFFFFFF;
        seen_q.delete();
        dbase = done_count;
        @(negedge clk);
        start = 1'b1;
        wait_done("line2", dbase, 20000);
        exp_q = {9'h001, 9'h080};
        for (int i = 0; i < 8; i++) exp_q.push_back(9'h130);
        exp_q.push_back(9'h0C0);
        for (int i = 0; i < 8; i++) exp_q.push_back(9'h146);
        check_seq("line2");
        start = 1'b0;
`endif

        chk("strobe width/stability", 32'(en_bad), 32'h0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
